// File: rtl/uart_rx_monitor.sv
// Simulation-side UART receiver: deserialises 8N1 frames from rx_i into a byte FIFO read over valid/ready.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity errors.
module uart_rx_monitor #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 256_000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CW           = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $fatal(1, "uart_rx_monitor: CLKS_PER_BIT must be >= 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_rx_monitor: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic parity_odd(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  // Stage p0/p1: two-flop synchroniser, idles high
  logic rx_p0, rx_p1, rx_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Frame FSM: control state is reset, the shift register is not
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_req, ferr_set, perr_set;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    push_req = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          perr_set = parity_odd(shift_q, par_q);
`endif
          if (rx_s) begin
            push_req = !perr_set;
            state_d  = IDLE;
          end else begin
            // A held-low line parks in BREAK instead of framing endless 0x00 bytes
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Error pulses are registered so they line up with the FIFO write timing
  logic frame_err_q, parity_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= ferr_set;
      parity_err_q <= perr_set;
    end
  end

  // Byte FIFO; data_q mirrors the head entry so data_o is defined out of reset
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]    count_q;
  logic [7:0]       data_q;
  logic             overflow_q, full, valid, pop, push_ok;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CNT_FULL);
  assign pop     = valid && ready_i;
  assign push_ok = push_req && (!full || pop);
  assign rd_nxt  = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_nxt;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (pop) begin
      if (count_q >= CW'(2))  data_q <= mem[rd_nxt];
      else if (push_ok)       data_q <= shift_q;
    end else if (push_ok && !valid) begin
      data_q <= shift_q;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid;
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
